// File: rtl/jt12_wr_seq_pkg.sv
// -----------------------------------------------------------------------------
// jt12_wr_seq_pkg
//   Shared types for the jt12_top host-side write sequencer.
//   - state_t : sequencer FSM states (IDLE, ADDR, AGAP, DATA, POLL)
//   - cmd_t   : one queued register write, packed as {part[16], reg[15:8], data[7:0]}
//   - bus_addr: forms the 2-bit jt12_top address for a given part / strobe phase
// -----------------------------------------------------------------------------
package jt12_wr_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,   // waiting for a queued command
        ST_ADDR = 3'd1,   // register-address write strobe active
        ST_AGAP = 3'd2,   // idle gap between address and data strobes
        ST_DATA = 3'd3,   // register-data write strobe active
        ST_POLL = 3'd4    // status read, waiting for busy (dout[7]) to clear
    } state_t;

    // Command word layout: bit 16 = part, bits 15:8 = register, bits 7:0 = data.
    localparam int CMD_W = 17;

    typedef struct packed {
        logic       part;
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cmd_t;

    // Part 0 uses addresses 0/1, part 1 uses 2/3; the low bit selects the
    // address port (0) or the data port (1).
    function automatic logic [1:0] bus_addr(input logic part, input logic data_phase);
        return {part, data_phase};
    endfunction

endpackage

// File: rtl/jt12_wr_seq_if.sv
// -----------------------------------------------------------------------------
// jt12_wr_seq_if
//   Groups the command handshake and the jt12_top CPU-bus signals of the
//   write sequencer.
//   master: the sequencer (accepts commands, drives addr/din/cs_n/wr_n, reads dout)
//   slave : the surroundings (command source plus jt12_top)
//   Signals:
//     cmd_valid/cmd_ready  command handshake, push on valid & ready
//     cmd_part/reg/data    command payload
//     dout                 jt12_top read data, bit 7 = busy
//     addr/din/cs_n/wr_n   jt12_top CPU-bus controls
// -----------------------------------------------------------------------------
interface jt12_wr_seq_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_part;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;
    logic [7:0] dout;
    logic [1:0] addr;
    logic [7:0] din;
    logic       cs_n;
    logic       wr_n;

    modport master (
        input  cmd_valid, cmd_part, cmd_reg, cmd_data, dout,
        output cmd_ready, addr, din, cs_n, wr_n
    );

    modport slave (
        output cmd_valid, cmd_part, cmd_reg, cmd_data, dout,
        input  cmd_ready, addr, din, cs_n, wr_n
    );

endinterface

// File: rtl/jt12_wr_fifo.sv
// -----------------------------------------------------------------------------
// jt12_wr_fifo
//   DEPTH-entry synchronous FIFO of 17-bit write commands, first-word
//   fall-through (rdata always shows the head entry when not empty).
//   Ports:
//     clk, rst      clock, synchronous active-high reset (empties the FIFO)
//     push, wdata   write request and data; ignored while full
//     pop           remove head entry; ignored while empty
//     rdata         head entry
//     full, empty   status flags from the registered count
//     level         occupancy, 0..DEPTH
//   Not gated by cen: pushes are accepted even while the sequencer is frozen.
// -----------------------------------------------------------------------------
module jt12_wr_fifo
    import jt12_wr_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  cmd_t                   wdata,
    input  logic                   pop,
    output cmd_t                   rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // NOTE: the storage array has no reset; only pointers and count do, since
    // an entry is never read before it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            unique case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/jt12_wr_seq.sv
// -----------------------------------------------------------------------------
// jt12_wr_seq
//   Host-side write sequencer for the jt12_top CPU bus. Queues (part, reg,
//   data) register writes and replays each as: address strobe, gap, data
//   strobe, then a status read polling the busy flag on dout[7].
//   Parameters:
//     DEPTH     command FIFO entries (power of 2, >= 2)
//     WR_PULSE  cen ticks cs_n/wr_n stay low per write strobe (>= 1)
//     ADDR_GAP  cen ticks between address and data strobes (>= 1)
//     POLL_TO   cen ticks in POLL before the busy wait is abandoned (2..255)
//   Ports:
//     clk, rst  system clock, synchronous active-high reset
//     cen       clock enable shared with jt12_top; FSM and timers only move on cen
//     bus       jt12_wr_seq_if.master: command handshake + jt12_top bus
//     idle      FIFO empty and FSM in IDLE
//     timeout   one-clk pulse when busy polling gave up
//     level     FIFO occupancy
// -----------------------------------------------------------------------------
module jt12_wr_seq
    import jt12_wr_seq_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int WR_PULSE = 2,
    parameter int ADDR_GAP = 2,
    parameter int POLL_TO  = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    jt12_wr_seq_if.master          bus,
    output logic                   idle,
    output logic                   timeout,
    output logic [$clog2(DEPTH):0] level
);

    // Terminal values of the shared 8-bit tick counter for each timed phase.
    localparam logic [7:0] PULSE_LAST = 8'(WR_PULSE - 1);
    localparam logic [7:0] GAP_LAST   = 8'(ADDR_GAP - 1);
    localparam logic [7:0] POLL_LAST  = 8'(POLL_TO - 1);

    // ---------------------------------------------------------------- FIFO --
    cmd_t push_cmd;
    cmd_t head;
    logic fifo_full;
    logic fifo_empty;
    logic pop;

    assign push_cmd = '{part: bus.cmd_part, reg_addr: bus.cmd_reg, data: bus.cmd_data};

    jt12_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cmd_valid),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign bus.cmd_ready = ~fifo_full;

    // ------------------------------------------------------------ state ----
    state_t     state,     state_nx;
    logic [7:0] cnt,       cnt_nx;
    logic [1:0] addr_q,    addr_nx;
    logic [7:0] din_q,     din_nx;
    logic       cs_n_q,    cs_n_nx;
    logic       wr_n_q,    wr_n_nx;
    logic       timeout_q, timeout_nx;
    // The command leaves the FIFO at the address strobe, so its part and data
    // are kept here for the data strobe.
    logic       cur_part,  part_nx;
    logic [7:0] cur_data,  data_nx;

    always_ff @(posedge clk) begin
        // NOTE: all sequential state is written with non-blocking assignments
        // so every register samples the values from before this edge.
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            cs_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            timeout_q <= 1'b0;
            cur_part  <= 1'b0;
            cur_data  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            addr_q    <= addr_nx;
            din_q     <= din_nx;
            cs_n_q    <= cs_n_nx;
            wr_n_q    <= wr_n_nx;
            timeout_q <= timeout_nx;
            cur_part  <= part_nx;
            cur_data  <= data_nx;
        end
    end

    always_comb begin
        // NOTE: every value assigned below gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nx   = state;
        cnt_nx     = cnt;
        addr_nx    = addr_q;
        din_nx     = din_q;
        cs_n_nx    = cs_n_q;
        wr_n_nx    = wr_n_q;
        part_nx    = cur_part;
        data_nx    = cur_data;
        timeout_nx = 1'b0;       // pulse lasts a single clk, cen or not
        pop        = 1'b0;

        if (cen) begin
            unique case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        part_nx  = head.part;
                        data_nx  = head.data;
                        addr_nx  = bus_addr(head.part, 1'b0);
                        din_nx   = head.reg_addr;
                        cs_n_nx  = 1'b0;
                        wr_n_nx  = 1'b0;
                        cnt_nx   = '0;
                        state_nx = ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (cnt == PULSE_LAST) begin
                        // din stays put through the gap, covering the
                        // one-tick hold after release.
                        cs_n_nx  = 1'b1;
                        wr_n_nx  = 1'b1;
                        cnt_nx   = '0;
                        state_nx = ST_AGAP;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end

                ST_AGAP: begin
                    if (cnt == GAP_LAST) begin
                        addr_nx  = bus_addr(cur_part, 1'b1);
                        din_nx   = cur_data;
                        cs_n_nx  = 1'b0;
                        wr_n_nx  = 1'b0;
                        cnt_nx   = '0;
                        state_nx = ST_DATA;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end

                ST_DATA: begin
                    if (cnt == PULSE_LAST) begin
                        cs_n_nx  = 1'b1;
                        wr_n_nx  = 1'b1;
                        cnt_nx   = '0;
                        state_nx = ST_POLL;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end

                ST_POLL: begin
                    // cnt holds the number of POLL ticks already taken. The
                    // first tick opens the status read (which also keeps din
                    // stable one tick past the data strobe); dout is trusted
                    // from the second tick on.
                    if (cnt == '0) begin
                        addr_nx = 2'b00;
                        cs_n_nx = 1'b0;
                        wr_n_nx = 1'b1;
                        cnt_nx  = 8'd1;
                    end else if (!bus.dout[7]) begin
                        cs_n_nx  = 1'b1;
                        state_nx = ST_IDLE;
                    end else if (cnt == POLL_LAST) begin
                        timeout_nx = 1'b1;
                        cs_n_nx    = 1'b1;
                        state_nx   = ST_IDLE;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end

                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------- outputs ----
    assign bus.addr = addr_q;
    assign bus.din  = din_q;
    assign bus.cs_n = cs_n_q;
    assign bus.wr_n = wr_n_q;
    assign timeout  = timeout_q;
    assign idle     = (state == ST_IDLE) && fifo_empty;

    // Only the busy flag of the status byte matters.
    logic unused_dout;
    assign unused_dout = ^bus.dout[6:0];

endmodule
